// File: rtl/traffic_pkg.sv
// Shared constants for the two-way traffic light controller and its request stage.
// Latency: none, constants only.
// Backpressure: none.
// Contents: controller phase encodings and the default duration width.
package traffic_pkg;

  // Default width of green-duration values; matches the controller countdown timers.
  localparam int TW_DEFAULT = 32;

  // Controller phase encodings, shared with the controller itself.
  localparam logic [1:0] PH_L1_GREEN  = 2'd0;
  localparam logic [1:0] PH_L1_YELLOW = 2'd1;
  localparam logic [1:0] PH_L2_GREEN  = 2'd2;
  localparam logic [1:0] PH_L2_YELLOW = 2'd3;

endpackage

// File: rtl/sensor_debounce.sv
// Synchronises and debounces one raw vehicle sensor; emits a one-cycle pulse per accepted rise.
// Latency: 2 sync cycles + DB_CYCLES stable cycles from sensor edge to accepted level change.
// Backpressure: none; the sensor is sampled every cycle.
// Ports: ck/rst_n clock and async active-low reset; sens raw sensor; rise one-cycle arrival pulse.
module sensor_debounce import traffic_pkg::*; #(
  parameter int DB_CYCLES = 16
) (
  input  logic ck,
  input  logic rst_n,
  input  logic sens,
  output logic rise
);

  localparam int             CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("sensor_debounce: DB_CYCLES must be at least 2");
  end

  logic          sync0;
  logic          sync1;
  logic          db;
  logic [CW-1:0] cnt;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync0 <= sens;
      sync1 <= sync0;
      rise  <= 1'b0;
      if (sync1 == db) begin
        // Any agreement, including a bounce back, restarts the stability count.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DB_CYCLES-th consecutive disagreeing sample: accept it.
        db   <= sync1;
        cnt  <= '0;
        rise <= sync1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_req_gen.sv
// Conditions both approach sensors into request flags and demand-stretched green durations.
// Latency: 1 cycle from accepted sensor rise to q/en, 1 cycle from green entry to ld/q update.
// Backpressure: none; arrival counters saturate at MAX_Q instead of stalling.
// Ports: ck/rst_n clock and async active-low reset; sens1/sens2 raw sensors; phase controller
//        phase; en1/en2 request pending; ld1/ld2 green durations; q1/q2 queued-arrival counts.
module traffic_req_gen import traffic_pkg::*; #(
  parameter int TW        = TW_DEFAULT,
  parameter int DB_CYCLES = 16,
  parameter int T_BASE    = 100,
  parameter int T_EXT     = 50,
  parameter int MAX_Q     = 4
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          sens1,
  input  logic          sens2,
  input  logic [1:0]    phase,
  output logic          en1,
  output logic          en2,
  output logic [TW-1:0] ld1,
  output logic [TW-1:0] ld2,
  output logic [2:0]    q1,
  output logic [2:0]    q2
);

  localparam logic [TW-1:0]      LD_BASE = TW'(T_BASE);
  localparam logic [TW-1:0]      LD_EXT  = TW'(T_EXT);
  localparam logic [2:0]         Q_MAX   = 3'(MAX_Q);
  localparam longint unsigned    LD_PEAK = longint'(T_BASE) + longint'(T_EXT) * longint'(MAX_Q - 1);

  if (MAX_Q < 1 || MAX_Q > 7) begin : g_bad_maxq
    $error("traffic_req_gen: MAX_Q must be in 1..7 to fit the 3-bit counters");
  end
  if (TW < 64 && LD_PEAK >= (64'd1 << TW)) begin : g_bad_tw
    $error("traffic_req_gen: longest green duration does not fit in TW bits");
  end

  logic [1:0]    sens_v;
  logic [1:0]    phase_d;
  logic [1:0]    en_v;
  logic [2:0]    q_v  [2];
  logic [TW-1:0] ld_v [2];

  assign sens_v = {sens2, sens1};

  // Delayed phase for green-entry detection; resetting to L1 green suppresses a
  // spurious approach-1 service on the first cycle out of reset.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) phase_d <= PH_L1_GREEN;
    else        phase_d <= phase;
  end

  for (genvar i = 0; i < 2; i++) begin : g_app
    localparam logic [1:0] PH_GREEN = (i == 0) ? PH_L1_GREEN : PH_L2_GREEN;

    logic       rise;
    logic       svc;
    logic [2:0] q;
    logic [2:0] q_ext;
    logic [2:0] q_nxt;

    sensor_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
      .ck    (ck),
      .rst_n (rst_n),
      .sens  (sens_v[i]),
      .rise  (rise)
    );

    always_comb begin
      svc   = (phase == PH_GREEN) && (phase_d != PH_GREEN);
      // Only arrivals beyond the first stretch the green.
      q_ext = (q > 3'd1) ? (q - 3'd1) : 3'd0;
      q_nxt = q;
      if (svc) begin
        // Service drains the queue, but an arrival landing on the same cycle is kept.
        q_nxt = {2'b00, rise};
      end else if (rise && (q < Q_MAX)) begin
        q_nxt = q + 3'd1;
      end
    end

    always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
        q       <= 3'd0;
        en_v[i] <= 1'b0;
        ld_v[i] <= LD_BASE;
      end else begin
        q       <= q_nxt;
        en_v[i] <= (q_nxt != 3'd0);
        if (svc) ld_v[i] <= LD_BASE + LD_EXT * TW'(q_ext);
      end
    end

    assign q_v[i] = q;
  end

  assign en1 = en_v[0];
  assign en2 = en_v[1];
  assign ld1 = ld_v[0];
  assign ld2 = ld_v[1];
  assign q1  = q_v[0];
  assign q2  = q_v[1];

endmodule
